// File: rtl/comparator_pkg.sv
// rtl/comparator_pkg.sv - shared state encoding and defaults for the comparator monitor
package comparator_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    localparam int unsigned DEF_SETTLE_CYCLES = 64;
    localparam int unsigned DEF_FILT_LEN      = 4;
    localparam int unsigned DEF_CNT_W         = 16;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/comparator_filter.sv
// rtl/comparator_filter.sv - comparator synchronizer, glitch filter and edge pulses
module comparator_filter
    import comparator_pkg::*;
#(
    parameter int unsigned FILT_LEN = DEF_FILT_LEN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic comp_raw,
    output logic comp_filt,
    output logic rise,
    output logic fall
);

    localparam int unsigned    FW        = cnt_width(FILT_LEN);
    localparam logic [FW-1:0]  FILT_LAST = FW'(FILT_LEN - 1);

    logic          sync_a;
    logic          sync_b;
    logic [FW-1:0] filt_cnt;
    logic          toggled;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= comp_raw;
            sync_b <= sync_a;
        end
    end

    // Outside ACTIVE the level is forced low silently; toggled stays clear so no fall pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_cnt  <= '0;
            comp_filt <= 1'b0;
            toggled   <= 1'b0;
        end else if (!run) begin
            filt_cnt  <= '0;
            comp_filt <= 1'b0;
            toggled   <= 1'b0;
        end else if (sync_b != comp_filt) begin
            if (filt_cnt == FILT_LAST) begin
                filt_cnt  <= '0;
                comp_filt <= ~comp_filt;
                toggled   <= 1'b1;
            end else begin
                filt_cnt  <= filt_cnt + FW'(1);
                toggled   <= 1'b0;
            end
        end else begin
            filt_cnt <= '0;
            toggled  <= 1'b0;
        end
    end

    assign rise = toggled & comp_filt;
    assign fall = toggled & ~comp_filt;

endmodule

// File: rtl/comparator_monitor.sv
// rtl/comparator_monitor.sv - bias sequencing, settle timer and rising-edge event counter
module comparator_monitor
    import comparator_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int unsigned FILT_LEN      = DEF_FILT_LEN,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             enable_i,
    input  logic             cnt_clr_i,
    input  logic             comp_i,
    output logic             bias_en_o,
    output logic             ready_o,
    output logic             comp_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic [CNT_W-1:0] rise_cnt_o
);

    localparam int unsigned   SW          = cnt_width(SETTLE_CYCLES);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    state_t        state;
    logic [SW-1:0] settle_cnt;
    logic          filt_run;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state      <= ST_OFF;
            settle_cnt <= '0;
            bias_en_o  <= 1'b0;
            ready_o    <= 1'b0;
        end else begin
            case (state)
                ST_OFF: begin
                    if (enable_i) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= '0;
                        bias_en_o  <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (!enable_i) begin
                        state     <= ST_OFF;
                        bias_en_o <= 1'b0;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        state   <= ST_ACTIVE;
                        ready_o <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end
                ST_ACTIVE: begin
                    if (!enable_i) begin
                        state     <= ST_OFF;
                        bias_en_o <= 1'b0;
                        ready_o   <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_OFF;
                    bias_en_o <= 1'b0;
                    ready_o   <= 1'b0;
                end
            endcase
        end
    end

    // Gating with enable_i clears the filter on the same edge the FSM leaves ACTIVE.
    assign filt_run = ready_o & enable_i;

    comparator_filter #(
        .FILT_LEN (FILT_LEN)
    ) u_filter (
        .clk       (wb_clk_i),
        .rst_n     (wb_rst_ni),
        .run       (filt_run),
        .comp_raw  (comp_i),
        .comp_filt (comp_o),
        .rise      (rise_o),
        .fall      (fall_o)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            rise_cnt_o <= '0;
        end else if (cnt_clr_i) begin
            rise_cnt_o <= '0;
        end else if (rise_o && (rise_cnt_o != '1)) begin
            rise_cnt_o <= rise_cnt_o + CNT_W'(1);
        end
    end

endmodule
